// File: rtl/burst_seq_pkg.sv
// Shared definitions for the burst sequencer slice.
// Contents: FSM state encoding, error code values, default burst length and
// the width of the hold/timeout timers.
package burst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_TRIG       = 3'd2,
        ST_WAIT_FIRST = 3'd3,
        ST_STREAM     = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_UNDERRUN = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    localparam int DEF_BURST_LEN = 2048;
    localparam int TMR_W         = 16;

endpackage

// File: rtl/burst_sequencer_seq_timer.sv
// seq_timer: loadable down-counter with a zero flag.
// Ports:
//   clk_in      in  clock, rising edge
//   rst_in      in  synchronous active-high reset (count -> 0)
//   load_in     in  load load_val_in this cycle (wins over counting)
//   load_val_in in  W-bit value to load
//   zero_out    out count is zero
// The count saturates at zero, so the flag stays up until the next load.
module seq_timer #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         load_in,
    input  logic [W-1:0] load_val_in,
    output logic         zero_out
);

    logic [W-1:0] count_r;

    // Count register: reset, load, or decrement towards zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_r <= W'(0);
        end else if (load_in) begin
            count_r <= load_val_in;
        end else if (count_r != W'(0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero_out = (count_r == W'(0));

endmodule

// File: rtl/burst_sequencer.sv
// burst_sequencer: sequences the data generator into the acquisition FIFO.
// Accepts a start with a burst count, waits for FIFO space, fires a
// registered trigger, and checks every burst for BURST_LEN contiguous words.
// Ports:
//   clk_in, rst_in           clock and synchronous active-high reset
//   start_in, burst_cnt_in   start request and number of bursts (IDLE only)
//   abort_in                 abort request, returns to IDLE without error
//   fifo_free_in             free words in the downstream FIFO
//   gen_valid_in             generator word strobe
//   trigger_out              generator trigger, TRIG_CYCLES cycles per burst
//   busy_out, done_out       run in progress / one-cycle completion pulse
//   error_out, err_code_out  sticky error and its cause
//   bursts_done_out          bursts completed in the current/last run
module burst_sequencer
    import burst_seq_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int CNT_W       = 16,
    parameter int TRIG_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic [CNT_W-1:0] burst_cnt_in,
    input  logic [15:0]      fifo_free_in,
    input  logic             gen_valid_in,
    output logic             trigger_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             error_out,
    output logic [1:0]       err_code_out,
    output logic [CNT_W-1:0] bursts_done_out
);

    localparam int WORD_W = $clog2(BURST_LEN + 1);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(BURST_LEN - 1);
    localparam logic [16:0]       FIFO_NEED  = 17'(BURST_LEN);
    // Timers count load..0, so loading N-1 gives a window of N cycles.
    localparam logic [TMR_W-1:0]  HOLD_LOAD  = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMO_LOAD   = TMR_W'(TIMEOUT - 1);

    state_e            state_r, state_nxt_s;
    logic              trig_r, trig_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;
    logic              err_r, err_nxt_s;
    logic [1:0]        code_r, code_nxt_s;
    logic [CNT_W-1:0]  bursts_r, bursts_nxt_s, bursts_inc_s;
    logic [CNT_W-1:0]  target_r, target_nxt_s;
    logic [WORD_W-1:0] words_r, words_nxt_s;
    logic              hold_load_s, hold_zero_s;
    logic              tmo_load_s, tmo_zero_s;

    // Both timers are loaded on entry to TRIG: one times the trigger hold,
    // the other the window from trigger rise to the first valid word.
    seq_timer #(.W(TMR_W)) u_hold_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (hold_load_s),
        .load_val_in (HOLD_LOAD),
        .zero_out    (hold_zero_s)
    );

    seq_timer #(.W(TMR_W)) u_tmo_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (tmo_load_s),
        .load_val_in (TMO_LOAD),
        .zero_out    (tmo_zero_s)
    );

    // Next-state, next-output and counter update logic.
    always_comb begin
        state_nxt_s  = state_r;
        done_nxt_s   = 1'b0;
        err_nxt_s    = err_r;
        code_nxt_s   = code_r;
        bursts_nxt_s = bursts_r;
        target_nxt_s = target_r;
        words_nxt_s  = words_r;
        hold_load_s  = 1'b0;
        tmo_load_s   = 1'b0;
        bursts_inc_s = bursts_r + CNT_W'(1);

        if ((state_r != ST_IDLE) && abort_in) begin
            // Abort beats any error detected in the same cycle.
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        target_nxt_s = burst_cnt_in;
                        err_nxt_s    = 1'b0;
                        code_nxt_s   = ERR_NONE;
                        bursts_nxt_s = CNT_W'(0);
                        words_nxt_s  = WORD_W'(0);
                        if (burst_cnt_in == CNT_W'(0)) begin
                            done_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_CHECK;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (gen_valid_in) begin
                        state_nxt_s = ST_IDLE;
                        err_nxt_s   = 1'b1;
                        code_nxt_s  = ERR_OVERRUN;
                    end else if ({1'b0, fifo_free_in} >= FIFO_NEED) begin
                        state_nxt_s = ST_TRIG;
                        hold_load_s = 1'b1;
                        tmo_load_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end
                ST_TRIG: begin
                    if (gen_valid_in) begin
                        state_nxt_s = ST_IDLE;
                        err_nxt_s   = 1'b1;
                        code_nxt_s  = ERR_OVERRUN;
                    end else if (hold_zero_s) begin
                        state_nxt_s = ST_WAIT_FIRST;
                    end else begin
                        state_nxt_s = ST_TRIG;
                    end
                end
                ST_WAIT_FIRST: begin
                    if (gen_valid_in) begin
                        state_nxt_s = ST_STREAM;
                        words_nxt_s = WORD_W'(1);
                    end else if (tmo_zero_s) begin
                        state_nxt_s = ST_IDLE;
                        err_nxt_s   = 1'b1;
                        code_nxt_s  = ERR_TIMEOUT;
                    end else begin
                        state_nxt_s = ST_WAIT_FIRST;
                    end
                end
                ST_STREAM: begin
                    if (!gen_valid_in) begin
                        state_nxt_s = ST_IDLE;
                        err_nxt_s   = 1'b1;
                        code_nxt_s  = ERR_UNDERRUN;
                    end else if (words_r == LAST_WORD) begin
                        // This cycle carries the last word of the burst.
                        words_nxt_s  = WORD_W'(0);
                        bursts_nxt_s = bursts_inc_s;
                        if (bursts_inc_s == target_r) begin
                            state_nxt_s = ST_IDLE;
                            done_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_CHECK;
                        end
                    end else begin
                        words_nxt_s = words_r + WORD_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        trig_nxt_s = (state_nxt_s == ST_TRIG);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, counter and registered-output update.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r  <= ST_IDLE;
            trig_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            code_r   <= ERR_NONE;
            bursts_r <= CNT_W'(0);
            target_r <= CNT_W'(0);
            words_r  <= WORD_W'(0);
        end else begin
            state_r  <= state_nxt_s;
            trig_r   <= trig_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            code_r   <= code_nxt_s;
            bursts_r <= bursts_nxt_s;
            target_r <= target_nxt_s;
            words_r  <= words_nxt_s;
        end
    end

    assign trigger_out     = trig_r;
    assign busy_out        = busy_r;
    assign done_out        = done_r;
    assign error_out       = err_r;
    assign err_code_out    = code_r;
    assign bursts_done_out = bursts_r;

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench for burst_sequencer: a behavioural generator answers
// each trigger rise with BURST_LEN words starting 3 cycles later (or a
// faulty variant), scenario records are run in a loop, and hand-written
// sequences cover reset, start/trigger timing, FIFO wait, timeout and reset
// during a burst.
module tb_burst_sequencer;

    localparam int BURST_LEN   = 2048;
    localparam int CNT_W       = 16;
    localparam int TRIG_CYCLES = 2;
    localparam int TIMEOUT     = 64;
    localparam int BUDGET      = 10000;

    typedef enum int {GEN_OFF, GEN_NORMAL, GEN_DROP, GEN_NONE, GEN_EXTRA} gen_mode_e;

    typedef struct {
        int        cnt;
        int        fifo;
        gen_mode_e mode;
        int        abort_at;
        int        exp_trig;
        int        exp_bd;
        int        exp_done;
        int        exp_err;
        int        exp_code;
    } scn_t;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             start_in;
    logic             abort_in;
    logic [CNT_W-1:0] burst_cnt_in;
    logic [15:0]      fifo_free_in;
    logic             gen_valid_in;
    logic             trigger_out;
    logic             busy_out;
    logic             done_out;
    logic             error_out;
    logic [1:0]       err_code_out;
    logic [CNT_W-1:0] bursts_done_out;

    gen_mode_e gen_mode = GEN_OFF;
    int        trig_rises = 0;
    int        done_cnt   = 0;
    int        bad_trig   = 0;
    int        n_tests    = 0;
    int        n_fail     = 0;

    burst_sequencer #(
        .BURST_LEN   (BURST_LEN),
        .CNT_W       (CNT_W),
        .TRIG_CYCLES (TRIG_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .abort_in        (abort_in),
        .burst_cnt_in    (burst_cnt_in),
        .fifo_free_in    (fifo_free_in),
        .gen_valid_in    (gen_valid_in),
        .trigger_out     (trigger_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .error_out       (error_out),
        .err_code_out    (err_code_out),
        .bursts_done_out (bursts_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Generator model and event monitor, updated just after each rising edge.
    initial begin : gen_monitor
        int   delay;
        int   left;
        int   trig_len;
        logic trig_prev;
        delay = 0; left = 0; trig_len = 0; trig_prev = 1'b0;
        gen_valid_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (trigger_out) trig_len++;
            if (trigger_out && !trig_prev) trig_rises++;
            if (!trigger_out && trig_prev) begin
                if (trig_len != TRIG_CYCLES) bad_trig++;
                trig_len = 0;
            end
            if (done_out) done_cnt++;
            if (gen_mode == GEN_OFF) begin
                delay = 0;
                left  = 0;
            end else if (trigger_out && !trig_prev && gen_mode != GEN_NONE) begin
                delay = 3;
            end else if (delay > 0) begin
                delay--;
                if (delay == 0) begin
                    left = (gen_mode == GEN_DROP)  ? 100 :
                           (gen_mode == GEN_EXTRA) ? BURST_LEN + 1 : BURST_LEN;
                end
            end
            trig_prev = trigger_out;
            if (left > 0) begin
                gen_valid_in = 1'b1;
                left--;
            end else begin
                gen_valid_in = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic gen_idle();
        gen_mode = GEN_OFF;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic do_start(input int cnt, input int fifo, input gen_mode_e mode);
        gen_mode     = mode;
        fifo_free_in = 16'(fifo);
        burst_cnt_in = CNT_W'(cnt);
        start_in     = 1'b1;
        @(negedge clk_in);
        start_in     = 1'b0;
        burst_cnt_in = CNT_W'(0);
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        for (cyc = 0; cyc < BUDGET; cyc++) begin
            if (!busy_out) break;
            @(negedge clk_in);
        end
        if (cyc == BUDGET) check({name, "_idle_timeout"}, 0, 1);
    endtask

    scn_t vec[7];

    initial begin : main
        int   t0, d0, b0, n, cyc, vcnt;
        logic vprev, seen;
        rst_in = 1'b1; start_in = 1'b0; abort_in = 1'b0;
        burst_cnt_in = CNT_W'(0); fifo_free_in = 16'd0;

        vec[0] = '{3, 4096, GEN_NORMAL, 0, 3, 3, 1, 0, 0};
        vec[1] = '{0, 4096, GEN_NORMAL, 0, 0, 0, 1, 0, 0};
        vec[2] = '{1, 4096, GEN_DROP,   0, 1, 0, 0, 1, 2};
        vec[3] = '{1, 4096, GEN_NONE,   0, 1, 0, 0, 1, 1};
        vec[4] = '{2, 4096, GEN_EXTRA,  0, 1, 1, 0, 1, 3};
        vec[5] = '{4, 4096, GEN_NORMAL, 1, 2, 1, 0, 0, 0};
        vec[6] = '{1, 2048, GEN_NORMAL, 0, 1, 1, 1, 0, 0};

        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_trigger", trigger_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_error", error_out, 0);
        check("rst_code", err_code_out, 0);
        check("rst_bursts", bursts_done_out, 0);

        // Start-to-trigger timing and end-of-run timing for one burst.
        do_start(1, 4096, GEN_NORMAL);
        check("t_busy_k1", busy_out, 1);
        check("t_trig_k1", trigger_out, 0);
        @(negedge clk_in); check("t_trig_k2", trigger_out, 1);
        @(negedge clk_in); check("t_trig_k3", trigger_out, 1);
        @(negedge clk_in); check("t_trig_k4", trigger_out, 0);
        vprev = 1'b0;
        for (cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk_in);
            if (done_out) break;
            vprev = gen_valid_in;
        end
        check("t_done_seen", int'(cyc < BUDGET), 1);
        check("t_done_busy", busy_out, 0);
        check("t_done_after_last", vprev, 1);
        check("t_done_bursts", bursts_done_out, 1);
        @(negedge clk_in); check("t_done_width", done_out, 0);
        gen_idle();

        // FIFO space wait, with a start request ignored while busy.
        t0 = trig_rises; d0 = done_cnt; seen = 1'b0;
        do_start(1, 1000, GEN_NORMAL);
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin burst_cnt_in = CNT_W'(5); start_in = 1'b1; end
            if (i == 11) begin burst_cnt_in = CNT_W'(0); start_in = 1'b0; end
            @(negedge clk_in);
            if (trigger_out) seen = 1'b1;
        end
        check("f_busy_wait", busy_out, 1);
        fifo_free_in = 16'd2047;
        repeat (5) begin @(negedge clk_in); if (trigger_out) seen = 1'b1; end
        check("f_no_trig", seen, 0);
        fifo_free_in = 16'd2048;
        @(negedge clk_in);
        check("f_trig_on_space", trigger_out, 1);
        wait_idle("f");
        repeat (3) @(negedge clk_in);
        check("f_bursts", bursts_done_out, 1);
        check("f_trig_count", trig_rises - t0, 1);
        check("f_done_count", done_cnt - d0, 1);
        check("f_error", error_out, 0);
        gen_idle();

        // Timeout measured from trigger rise to error.
        do_start(1, 4096, GEN_NONE);
        for (cyc = 0; cyc < 20 && !trigger_out; cyc++) @(negedge clk_in);
        n = 0;
        for (cyc = 0; cyc < 200 && !error_out; cyc++) begin
            @(negedge clk_in);
            n++;
        end
        check("to_cycles", n, TIMEOUT);
        check("to_code", err_code_out, 1);
        check("to_busy", busy_out, 0);
        gen_idle();

        // Scenario table.
        for (int s = 0; s < 7; s++) begin
            t0 = trig_rises; d0 = done_cnt; b0 = bad_trig; vcnt = 0;
            do_start(vec[s].cnt, vec[s].fifo, vec[s].mode);
            for (cyc = 0; cyc < BUDGET; cyc++) begin
                if (abort_in) abort_in = 1'b0;
                if (!busy_out) break;
                if (vec[s].abort_at > 0 && int'(bursts_done_out) == vec[s].abort_at
                        && gen_valid_in) begin
                    vcnt++;
                    if (vcnt == 50) abort_in = 1'b1;
                end
                @(negedge clk_in);
            end
            if (cyc == BUDGET) check($sformatf("s%0d_idle_timeout", s), 0, 1);
            repeat (3) @(negedge clk_in);
            check($sformatf("s%0d_triggers", s), trig_rises - t0, vec[s].exp_trig);
            check($sformatf("s%0d_bursts", s), bursts_done_out, vec[s].exp_bd);
            check($sformatf("s%0d_done", s), done_cnt - d0, vec[s].exp_done);
            check($sformatf("s%0d_error", s), error_out, vec[s].exp_err);
            check($sformatf("s%0d_code", s), err_code_out, vec[s].exp_code);
            check($sformatf("s%0d_trig_len", s), bad_trig - b0, 0);
            gen_idle();
        end

        // Reset during a burst: immediate reset values, trailing words ignored.
        do_start(2, 4096, GEN_NORMAL);
        for (cyc = 0; cyc < 100 && !gen_valid_in; cyc++) @(negedge clk_in);
        repeat (20) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("r_busy", busy_out, 0);
        check("r_bursts", bursts_done_out, 0);
        check("r_trigger", trigger_out, 0);
        repeat (50) @(negedge clk_in);
        check("r_busy_later", busy_out, 0);
        check("r_error_later", error_out, 0);
        gen_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_sequencer.md
# burst_sequencer

Controller that sequences the data generator into the acquisition FIFO. Accepts a start command with a burst count, waits for enough FIFO space, fires the generator trigger, and checks each burst for exactly BURST_LEN contiguous valid words. Reports busy/done/error to the host-side control logic. Sits between the control register interface and the generator/FIFO pair.

## Interface
- BURST_LEN, 2048: words per generator burst (≥ 2).
- CNT_W, 16: width of burst count / completed-burst counter.
- TRIG_CYCLES, 2: cycles trigger_out is held high per burst (≥ 1).
- TIMEOUT, 64: max cycles from trigger rise to first valid word.
- clk_in  in  1  single clock, all logic on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- start_in  in  1  start request, sampled in IDLE only.
- abort_in  in  1  abort request, highest priority after reset.
- burst_cnt_in  in  CNT_W  bursts to run; latched when start is accepted.
- fifo_free_in  in  16  free word count of downstream FIFO.
- gen_valid_in  in  1  generator valid output.
- trigger_out  out  1  generator trigger, registered.
- busy_out  out  1  high from start acceptance until return to IDLE.
- done_out  out  1  one-cycle pulse on successful completion.
- error_out  out  1  sticky error flag; cleared on next accepted start.
- err_code_out  out  2  0 none, 1 timeout, 2 underrun, 3 overrun; held with error_out.
- bursts_done_out  out  CNT_W  bursts completed in current/last run.

## Operation
- States: IDLE, CHECK, TRIG, WAIT_FIRST, STREAM.
- IDLE: start_in=1 → latch burst_cnt_in, clear error_out/err_code_out/bursts_done_out; if burst_cnt_in=0 → done_out pulse next cycle, stay IDLE, busy_out stays 0; else → CHECK. start_in ignored in all other states.
- CHECK: fifo_free_in ≥ BURST_LEN → TRIG; else stay.
- TRIG: trigger_out=1 for exactly TRIG_CYCLES cycles, then → WAIT_FIRST with trigger_out=0.
- WAIT_FIRST: gen_valid_in=1 → word counter=1, → STREAM. Timeout counter starts at trigger rise; reaching TIMEOUT cycles with no valid → error code 1.
- STREAM: each cycle with gen_valid_in=1 increments word counter. gen_valid_in=0 before BURST_LEN words → error code 2. Cycle carrying word BURST_LEN → bursts_done_out+1; if it equals latched count → IDLE with done_out pulse; else → CHECK.
- gen_valid_in=1 while in CHECK or TRIG → error code 3 (overrun).
- Any error: error_out=1, err_code_out set, → IDLE, trigger_out=0, busy_out=0, no done_out.
- abort_in=1 in any non-IDLE state → IDLE next cycle, trigger_out=0, busy_out=0; no done_out, no error; bursts_done_out keeps value. abort_in in IDLE ignored. abort and error in same cycle: abort wins, no error.
- Word counter width clog2(BURST_LEN+1); bursts_done_out does not wrap (bounded by latched count).

## Timing
- Reset: state IDLE; trigger_out, busy_out, done_out, error_out = 0; err_code_out = 0; bursts_done_out = 0; all counters 0.
- Start sampled at edge k: busy_out=1 from k+1 (CHECK). FIFO space available: trigger_out rises at k+2, falls at k+2+TRIG_CYCLES.
- Generator asserts valid 3 cycles after trigger rise; first valid at k+5.
- done_out and busy_out fall in the cycle immediately after the last valid word of the last burst.
- Back-to-back bursts: next trigger rises 2 cycles after the last valid word when FIFO space is available.
- Reset mid-operation: immediate return to reset values; the generator may still finish a burst, and those words are ignored in IDLE.

## Structure
- Shared package burst_seq_pkg: state enum, err_code localparams (ERR_NONE/TIMEOUT/UNDERRUN/OVERRUN), default BURST_LEN.
- One sub-module: seq_timer, a loadable down-counter used for the TRIG_CYCLES hold and the TIMEOUT window, with a zero flag.

## Test plan
- Bench pairs the sequencer with a behavioural generator model (valid 3 cycles after trigger rise, BURST_LEN contiguous words).
- burst_cnt_in=3, fifo_free_in=4096 → 3 triggers, each held 2 cycles; bursts_done_out 1,2,3; single done_out; error_out=0.
- fifo_free_in=1000 for 50 cycles, then 2048 → trigger only after free reaches 2048; one burst completes.
- Generator model drops valid after word 100 → error_out=1, err_code_out=2, busy_out=0, no done_out.
- Generator never responds → error 1 exactly TIMEOUT=64 cycles after trigger rise. Extra valid word after burst → error 3.
- abort_in mid-STREAM on burst 2 of 4 → IDLE next cycle, bursts_done_out=1, no done/error. burst_cnt_in=0 → done_out pulse, no trigger. start_in while busy → ignored.
